// File: rtl/scalar_product_seq_if.sv
// Streaming handshake bundle between a vector source, the scalar-product
// controller and the consumer of its result.
interface scalar_product_seq_if #(
  parameter int SIZE_INT = 32,
  parameter int LANES    = 8
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*SIZE_INT-1:0] IX;
  logic [LANES*SIZE_INT-1:0] IY;
  logic                      busy;
  logic                      done;
  logic [SIZE_INT-1:0]       result;

  modport master (
    output start, in_valid, IX, IY,
    input  in_ready, busy, done, result
  );

  modport slave (
    input  start, in_valid, IX, IY,
    output in_ready, busy, done, result
  );
endinterface

// File: rtl/scalar_product_seq.sv
// Beat-serial scalar product: LANES lane products per beat are summed into a
// registered partial, which is folded into one shared accumulator a cycle later.
module scalar_product_seq #(
  parameter int SIZE_INT = 32,
  parameter int VEC_LEN  = 256,
  parameter int LANES    = 8
) (
  input logic                clk,
  input logic                reset,
  scalar_product_seq_if.slave bus
);
  localparam int N_BEATS = VEC_LEN / LANES;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [SIZE_INT-1:0] acc_q, acc_d;
  logic [SIZE_INT-1:0] part_q, part_d;
  logic                part_v_q, part_v_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SIZE_INT-1:0] lane_sum;
  logic                accept;
  logic                last_beat;

  assign bus.in_ready = (state_q == LOAD);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = acc_q;

  assign accept    = bus.in_valid && (state_q == LOAD);
  assign last_beat = (cnt_q == CNT_W'(N_BEATS - 1));

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SIZE_INT'(bus.IX[i*SIZE_INT +: SIZE_INT] *
                                      bus.IY[i*SIZE_INT +: SIZE_INT]);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    part_d   = part_q;
    part_v_d = part_v_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          cnt_d    = '0;
          part_v_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // The partial from the previous cycle is folded in whether or not a new beat arrives.
        if (part_v_q) begin
          acc_d = acc_q + part_q;
        end
        part_v_d = accept;
        if (accept) begin
          part_d = lane_sum;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (part_v_q) begin
          acc_d = acc_q + part_q;
        end
        part_v_d = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      part_q   <= '0;
      part_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      part_q   <= part_d;
      part_v_q <= part_v_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
